// File: rtl/sdram_arb_pkg.sv
// Shared types for the two-port SDRAM arbiter: FSM states, port select, arbitration modes.
package sdram_arb_pkg;

    localparam int ADDR_W = 21;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 10;

    localparam int ARB_FIXED = 0;   // B always wins a tie
    localparam int ARB_RR    = 1;   // tie goes to the port opposite the last grant

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_GAP
    } arb_state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_sel_t;

endpackage

// File: rtl/sdram_req_slot.sv
// One requester's pending slot: rising-edge detect on req, pending flag, operand latch.
module sdram_req_slot
    import sdram_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic              i_wren,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_clr,
    output logic              o_pend,
    output logic              o_wren,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_wdata
);

    logic              r_prev;
    logic              r_pend;
    logic              r_wren;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              w_edge;

    assign w_edge  = i_req & ~r_prev;
    assign o_pend  = r_pend;
    assign o_wren  = r_wren;
    assign o_addr  = r_addr;
    assign o_wdata = r_wdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev  <= 1'b0;
            r_pend  <= 1'b0;
            r_wren  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_prev <= i_req;
            // An edge while still pending is dropped so the in-flight operands stay intact.
            if (i_clr) begin
                r_pend <= 1'b0;
            end else if (w_edge && !r_pend) begin
                r_pend  <= 1'b1;
                r_wren  <= i_wren;
                r_addr  <= i_addr;
                r_wdata <= i_wdata;
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller port between CPU PRG (A) and PPU CHR (B) requesters.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int          ARB_MODE   = ARB_FIXED,
    parameter logic [20:0] B_BASE     = 21'h100000,
    parameter int          WAIT_LIMIT = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_wren,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_ready,
    input  logic              b_req,
    input  logic              b_wren,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] to_mem,
    output logic              mem_req,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] from_mem,
    input  logic              mem_ready,
    output logic              busy,
    output logic              timeout
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

    arb_state_t        r_state;
    port_sel_t         r_owner;
    port_sel_t         r_last;
    logic [CNT_W-1:0]  r_wait_cnt;

    logic              w_a_pend, w_a_wren, w_b_pend, w_b_wren;
    logic [ADDR_W-1:0] w_a_addr, w_b_addr, w_iss_addr;
    logic [DATA_W-1:0] w_a_wdata, w_b_wdata;
    logic              w_done, w_any;
    port_sel_t         w_sel;

    assign w_done = (r_state == S_WAIT) && mem_ready;
    assign w_any  = w_a_pend | w_b_pend;

    sdram_req_slot u_slot_a (
        .clk(clk), .rst_n(rst_n),
        .i_req(a_req), .i_wren(a_wren), .i_addr(a_addr), .i_wdata(a_wdata),
        .i_clr(w_done && (r_owner == PORT_A)),
        .o_pend(w_a_pend), .o_wren(w_a_wren), .o_addr(w_a_addr), .o_wdata(w_a_wdata)
    );

    sdram_req_slot u_slot_b (
        .clk(clk), .rst_n(rst_n),
        .i_req(b_req), .i_wren(b_wren), .i_addr(b_addr), .i_wdata(b_wdata),
        .i_clr(w_done && (r_owner == PORT_B)),
        .o_pend(w_b_pend), .o_wren(w_b_wren), .o_addr(w_b_addr), .o_wdata(w_b_wdata)
    );

    always_comb begin
        w_sel = PORT_A;
        if (w_a_pend && w_b_pend)
            w_sel = (ARB_MODE == ARB_RR && r_last == PORT_B) ? PORT_A : PORT_B;
        else if (w_b_pend)
            w_sel = PORT_B;
    end

    // 21-bit sum wraps modulo 2^21 by construction.
    assign w_iss_addr = (w_sel == PORT_B) ? (w_b_addr + B_BASE) : w_a_addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_owner     <= PORT_A;
            r_last      <= PORT_A;
            r_wait_cnt  <= '0;
            mem_address <= '0;
            to_mem      <= '0;
            mem_req     <= 1'b0;
            mem_wren    <= 1'b0;
            busy        <= 1'b0;
            timeout     <= 1'b0;
            a_rdata     <= '0;
            b_rdata     <= '0;
            a_ready     <= 1'b0;
            b_ready     <= 1'b0;
        end else begin
            a_ready <= 1'b0;
            b_ready <= 1'b0;
            case (r_state)
                // The gap cycle itself is the single low cycle of mem_req; a pending slot
                // is issued straight out of it so the controller sees exactly one low cycle.
                S_IDLE, S_GAP: begin
                    if (w_any) begin
                        r_owner     <= w_sel;
                        mem_address <= w_iss_addr;
                        to_mem      <= (w_sel == PORT_B) ? w_b_wdata : w_a_wdata;
                        mem_wren    <= (w_sel == PORT_B) ? w_b_wren : w_a_wren;
                        mem_req     <= 1'b1;
                        busy        <= 1'b1;
                        r_wait_cnt  <= '0;
                        r_state     <= S_WAIT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (mem_ready) begin
                        mem_req    <= 1'b0;
                        busy       <= 1'b0;
                        r_last     <= r_owner;
                        r_wait_cnt <= '0;
                        r_state    <= S_GAP;
                        if (r_owner == PORT_A) begin
                            a_ready <= 1'b1;
                            if (!mem_wren) a_rdata <= from_mem;
                        end else begin
                            b_ready <= 1'b1;
                            if (!mem_wren) b_rdata <= from_mem;
                        end
                    end else begin
                        if (r_wait_cnt != LIMIT) r_wait_cnt <= r_wait_cnt + 1'b1;
                        if (r_wait_cnt >= LIMIT - 1'b1) timeout <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: fixed-priority and round-robin instances driven in parallel.
module tb_sdram_port_arbiter;

    localparam logic [20:0] B_BASE     = 21'h100000;
    localparam int          WAIT_LIMIT = 1023;

    typedef struct packed {
        logic [20:0] addr;
        logic        wren;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
    } iss_t;

    typedef struct packed {
        logic       port;
        logic [7:0] rdata;
    } rdy_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        a_req, a_wren, b_req, b_wren;
    logic [20:0] a_addr, b_addr;
    logic [7:0]  a_wdata, b_wdata;

    logic [7:0]  a_rdata[2], b_rdata[2], to_mem[2], from_mem[2];
    logic [20:0] mem_address[2];
    logic        a_ready[2], b_ready[2], mem_req[2], mem_wren[2], mem_ready[2];
    logic        busy[2], timeout[2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sdram_port_arbiter #(.ARB_MODE(g), .B_BASE(B_BASE), .WAIT_LIMIT(WAIT_LIMIT)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .a_req(a_req), .a_wren(a_wren), .a_addr(a_addr), .a_wdata(a_wdata),
            .a_rdata(a_rdata[g]), .a_ready(a_ready[g]),
            .b_req(b_req), .b_wren(b_wren), .b_addr(b_addr), .b_wdata(b_wdata),
            .b_rdata(b_rdata[g]), .b_ready(b_ready[g]),
            .mem_address(mem_address[g]), .to_mem(to_mem[g]), .mem_req(mem_req[g]),
            .mem_wren(mem_wren[g]), .from_mem(from_mem[g]), .mem_ready(mem_ready[g]),
            .busy(busy[g]), .timeout(timeout[g])
        );
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Controller model: answers each request after rsp_delay cycles, logs what was issued.
    int          rsp_delay = 0;
    logic        rsp_fix = 1'b0;
    logic [7:0]  rsp_fix_data = 8'h00;
    iss_t        iss_q[2][$];
    rdy_t        rdy_q[2][$];
    int          gap_q[2][$];
    int          hi_q[2][$];
    iss_t        cur[2];
    int          rcnt[2], rdly[2];
    bit          rbusy[2];
    logic        mr_seen[2];

    task automatic fire(input int m);
        mem_ready[m] = 1'b1;
        from_mem[m]  = rsp_fix ? rsp_fix_data : 8'($urandom);
        cur[m].rdata = from_mem[m];
        iss_q[m].push_back(cur[m]);
        rbusy[m] = 1'b0;
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            mem_ready[m] = 1'b0; from_mem[m] = 8'h00; rbusy[m] = 1'b0; rcnt[m] = 0; rdly[m] = 0;
        end
        forever begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                mem_ready[m] = 1'b0;
                if (!rst_n) begin
                    rbusy[m] = 1'b0;
                end else if (rbusy[m]) begin
                    chk("held_stable", {mem_address[m], mem_wren[m], to_mem[m]},
                        {cur[m].addr, cur[m].wren, cur[m].wdata});
                    rcnt[m]++;
                    if (rcnt[m] >= rdly[m]) fire(m);
                end else if (mem_req[m]) begin
                    cur[m] = '{addr: mem_address[m], wren: mem_wren[m], wdata: to_mem[m], rdata: 8'h00};
                    rcnt[m] = 0;
                    rdly[m] = rsp_delay;
                    rbusy[m] = 1'b1;
                    if (rdly[m] == 0) fire(m);
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        for (int m = 0; m < 2; m++) mr_seen[m] = mem_ready[m];
    end

    // Port-side monitor: ready pulses, mem_req high/low run lengths.
    initial begin
        int  low_run[2], hi[2];
        logic preq[2];
        for (int m = 0; m < 2; m++) begin low_run[m] = 100; hi[m] = 0; preq[m] = 1'b0; end
        forever begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                if (a_ready[m] || b_ready[m]) begin
                    chk("ready_after_mem_ready", mr_seen[m], 1);
                    chk("single_ready", a_ready[m] & b_ready[m], 0);
                    rdy_q[m].push_back('{port: b_ready[m], rdata: b_ready[m] ? b_rdata[m] : a_rdata[m]});
                end
                if (mem_req[m] && !preq[m]) begin
                    gap_q[m].push_back(low_run[m]); hi[m] = 1;
                end else if (mem_req[m]) begin
                    hi[m]++;
                end else if (preq[m]) begin
                    hi_q[m].push_back(hi[m]); low_run[m] = 1;
                end else begin
                    low_run[m]++;
                end
                preq[m] = mem_req[m];
            end
        end
    end

    // Reference model state: per instance last grant and visible rdata per port.
    logic [20:0] st_addr[2];
    logic        st_wren[2];
    logic [7:0]  st_wdata[2];
    logic [7:0]  m_rdata[2][2];
    int          m_last[2];

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_last[m] = 0; m_rdata[m][0] = 8'h00; m_rdata[m][1] = 8'h00;
            iss_q[m].delete(); rdy_q[m].delete(); gap_q[m].delete(); hi_q[m].delete();
        end
    endtask

    task automatic randomize_port(input int p);
        st_addr[p]  = 21'($urandom);
        st_wren[p]  = 1'($urandom);
        st_wdata[p] = 8'($urandom);
    endtask

    task automatic drive_ports(input int sel);
        @(negedge clk);
        a_addr = st_addr[0]; a_wren = st_wren[0]; a_wdata = st_wdata[0];
        b_addr = st_addr[1]; b_wren = st_wren[1]; b_wdata = st_wdata[1];
        a_req = sel[0]; b_req = sel[1];
        @(negedge clk);
        a_req = 1'b0; b_req = 1'b0;
    endtask

    task automatic wait_ready(input int n, input int budget);
        int cyc = 0;
        while ((rdy_q[0].size() < n || rdy_q[1].size() < n) && cyc < budget) begin
            @(negedge clk); cyc++;
        end
        @(negedge clk);
        for (int m = 0; m < 2; m++) chk("ready_count", rdy_q[m].size(), n);
    endtask

    task automatic check_phase(input int sel, input int dly);
        int n, first, p, gap, hl, exp_addr;
        iss_t e;
        rdy_t r;
        n = (sel == 3) ? 2 : 1;
        for (int m = 0; m < 2; m++) begin
            if (sel == 3) first = (m == 0) ? 1 : (m_last[m] == 0 ? 1 : 0);
            else          first = (sel == 2) ? 1 : 0;
            for (int k = 0; k < n; k++) begin
                p = (k == 0) ? first : 1 - first;
                if (iss_q[m].size() == 0 || rdy_q[m].size() == 0 ||
                    gap_q[m].size() == 0 || hi_q[m].size() == 0) begin
                    chk("txn_logged", 0, 1);
                    continue;
                end
                e = iss_q[m].pop_front();
                r = rdy_q[m].pop_front();
                gap = gap_q[m].pop_front();
                hl = hi_q[m].pop_front();
                exp_addr = (p == 1) ? (int'(st_addr[1]) + int'(B_BASE)) % (1 << 21) : int'(st_addr[0]);
                chk("mem_address", 32'(e.addr), exp_addr);
                chk("mem_wren", e.wren, st_wren[p]);
                if (st_wren[p]) chk("to_mem", e.wdata, st_wdata[p]);
                chk("ready_port", r.port, p);
                if (!st_wren[p]) m_rdata[m][p] = e.rdata;
                chk("rdata", r.rdata, m_rdata[m][p]);
                if (k == 1) chk("gap_low_cycles", gap, 1);
                chk("req_high_cycles", hl, dly + 1);
                m_last[m] = p;
            end
            chk("leftover_ready", rdy_q[m].size(), 0);
        end
    endtask

    task automatic phase(input int sel, input int dly);
        rsp_delay = dly;
        drive_ports(sel);
        wait_ready((sel == 3) ? 2 : 1, 60);
        check_phase(sel, dly);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int sel, cyc;
        rst_n = 1'b0; a_req = 1'b0; b_req = 1'b0; a_wren = 1'b0; b_wren = 1'b0;
        a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
        for (int p = 0; p < 2; p++) begin st_addr[p] = '0; st_wren[p] = 1'b0; st_wdata[p] = '0; end
        model_reset();
        repeat (3) @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            chk("reset_data", {a_rdata[m], b_rdata[m], to_mem[m]}, 0);
            chk("reset_ctrl", {mem_address[m], a_ready[m], b_ready[m], mem_req[m], mem_wren[m],
                               busy[m], timeout[m]}, 0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single A read with a fixed controller answer.
        st_addr[0] = 21'h00123; st_wren[0] = 1'b0; rsp_fix = 1'b1; rsp_fix_data = 8'h5A;
        phase(1, 5);
        for (int m = 0; m < 2; m++) chk("a_rdata_5A", a_rdata[m], 8'h5A);
        rsp_fix = 1'b0;

        // Single B write; B_BASE offset applied, b_rdata untouched.
        st_addr[1] = 21'h00040; st_wren[1] = 1'b1; st_wdata[1] = 8'hC3;
        phase(2, 3);

        // Simultaneous edges, then back-to-back contention.
        st_wren[0] = 1'b0; st_wren[1] = 1'b0;
        phase(3, 2);
        for (int i = 0; i < 3; i++) begin randomize_port(0); randomize_port(1); phase(3, i); end

        // B address wraps past the top of the 21-bit space.
        st_addr[1] = 21'h1FFFFF; st_wren[1] = 1'b0;
        phase(2, 1);

        for (int i = 0; i < 30; i++) begin
            sel = $urandom_range(1, 3);
            randomize_port(0); randomize_port(1);
            phase(sel, $urandom_range(0, 6));
        end

        // Long wait: timeout sets once the grant has waited WAIT_LIMIT cycles, then sticks.
        randomize_port(0); st_wren[0] = 1'b0;
        rsp_delay = 1100;
        drive_ports(1);
        cyc = 0;
        while (!mem_req[0] && cyc < 10) begin @(negedge clk); cyc++; end
        chk("timeout_grant_seen", mem_req[0], 1);
        for (int k = 1; k <= WAIT_LIMIT; k++) begin
            @(negedge clk);
            if (k == WAIT_LIMIT - 1) for (int m = 0; m < 2; m++) chk("timeout_before_limit", timeout[m], 0);
            if (k == WAIT_LIMIT) for (int m = 0; m < 2; m++) begin
                chk("timeout_at_limit", timeout[m], 1);
                chk("busy_while_waiting", busy[m], 1);
            end
        end
        wait_ready(1, 200);
        check_phase(1, 1100);
        for (int m = 0; m < 2; m++) chk("timeout_sticky", timeout[m], 1);

        // Reset in the middle of a grant abandons it.
        randomize_port(0);
        rsp_delay = 50;
        drive_ports(1);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            chk("rst_mid_mem_req", mem_req[m], 0);
            chk("rst_mid_busy", busy[m], 0);
            chk("rst_mid_timeout", timeout[m], 0);
            chk("rst_mid_a_rdata", a_rdata[m], 0);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        for (int m = 0; m < 2; m++) chk("rst_pending_cleared", mem_req[m], 0);
        model_reset();
        randomize_port(0); phase(1, 2);
        randomize_port(0); randomize_port(1); phase(3, 1);
        randomize_port(0); randomize_port(1); phase(3, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
